// File: rtl/inst_mem_loader_pkg.sv
// Shared definitions for the boot-time instruction memory loader.
package inst_mem_loader_pkg;

    localparam logic [7:0] LOADER_MAGIC = 8'hA5;
    localparam int         LEN_W        = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_CHECK,
        ST_DONE,
        ST_ERR
    } loader_state_t;

endpackage

// File: rtl/inst_mem_loader.sv
// Framed byte-stream programmer for the instruction memory byte write port.
// Holds the core in reset until an image with a matching XOR checksum is loaded.
module inst_mem_loader
    import inst_mem_loader_pkg::*;
#(
    parameter int MEM_BYTES = 1024,
    parameter int ADDR_W    = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   byte_count
);

    localparam logic [LEN_W-1:0] MEM_LIMIT = LEN_W'(MEM_BYTES);

    // Handshake: a byte moves when in_valid && in_ready on a rising edge.
    // in_ready is registered from the next state only, never from in_valid.
    loader_state_t    state;
    loader_state_t    next_state;
    logic [7:0]       len_lo;
    logic [LEN_W-1:0] len;
    logic [7:0]       checksum;

    logic             accept;
    logic [LEN_W-1:0] len_full;
    logic             len_legal;
    logic [LEN_W-1:0] count_inc;

    assign accept    = in_valid && in_ready;
    assign len_full  = {in_data, len_lo};
    assign len_legal = (len_full != '0) && (len_full[1:0] == 2'b00) &&
                       (len_full <= MEM_LIMIT);
    assign count_inc = LEN_W'(byte_count) + LEN_W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (start) next_state = ST_SYNC;
            ST_SYNC:   if (accept && in_data == LOADER_MAGIC) next_state = ST_LEN_LO;
            ST_LEN_LO: if (accept) next_state = ST_LEN_HI;
            ST_LEN_HI: if (accept) next_state = len_legal ? ST_DATA : ST_ERR;
            ST_DATA:   if (accept && count_inc == len) next_state = ST_CHECK;
            ST_CHECK:  if (accept) next_state = (in_data == checksum) ? ST_DONE : ST_ERR;
            ST_DONE:   if (start) next_state = ST_SYNC;
            ST_ERR:    if (start) next_state = ST_SYNC;
            default:   next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_ready   <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            byte_count <= '0;
            checksum   <= '0;
            len_lo     <= '0;
            len        <= '0;
        end else begin
            wr_en <= 1'b0;
            if (state == ST_LEN_LO && accept) begin
                len_lo <= in_data;
            end
            if (state == ST_LEN_HI && accept) begin
                len <= len_full;
                if (len_legal) begin
                    byte_count <= '0;
                    checksum   <= '0;
                end
            end
            // The write for an accepted payload byte lands exactly one cycle later.
            if (state == ST_DATA && accept) begin
                wr_en      <= 1'b1;
                wr_addr    <= byte_count[ADDR_W-1:0];
                wr_data    <= in_data;
                byte_count <= byte_count + 1'b1;
                checksum   <= checksum ^ in_data;
            end
            in_ready <= (next_state == ST_SYNC)   || (next_state == ST_LEN_LO) ||
                        (next_state == ST_LEN_HI) || (next_state == ST_DATA)   ||
                        (next_state == ST_CHECK);
            done     <= (next_state == ST_DONE);
            error    <= (next_state == ST_ERR);
            cpu_hold <= (next_state != ST_DONE);
        end
    end

endmodule
